clock_divider_ce: RTL

//  Programmable integer clock divider and clock-enable generator. It is the divide-down counterpart of the

---
 rtl/clock_divider_ce.sv | 127 ++++++++++++
 1 files changed

// File: rtl/clock_divider_ce.sv
// Programmable integer clock divider: one-cycle clk_en every Neff cycles, registered divided clock,
// run/halt/single-step control, and divisor reloads deferred to period boundaries.
module clock_divider_ce #(
   parameter int unsigned CNT_W       = 16,
   parameter int unsigned DEFAULT_DIV = 2
) (
   input  logic             clk_in,
   input  logic             rst,
   input  logic             run,
   input  logic             step,
   input  logic [CNT_W-1:0] div_in,
   input  logic             div_load,
   output logic             div_ack,
   output logic [CNT_W-1:0] div_cur,
   output logic             clk_en,
   output logic             clk_div,
   output logic             busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      STEP = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] div_cur_q, div_cur_d;
   logic [CNT_W-1:0] pend_val_q, pend_val_d;
   logic             pend_q, pend_d;
   logic             clk_en_q, clk_en_d;
   logic             clk_div_q, clk_div_d;
   logic             div_ack_q, div_ack_d;

   logic [CNT_W-1:0] neff;
   logic [CNT_W-1:0] neff_nx;
   logic             active;
   logic             wrap;
   logic             apply;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      div_cur_d  = div_cur_q;
      pend_val_d = pend_val_q;
      pend_d     = pend_q;
      clk_en_d   = 1'b0;
      clk_div_d  = 1'b0;
      div_ack_d  = 1'b0;

      neff   = (div_cur_q == '0) ? CNT_W'(1) : div_cur_q;
      active = (state_q != IDLE);
      wrap   = active && (cnt_q >= neff - CNT_W'(1));

      // Divisor swaps only where a period starts, so the count never straddles two lengths.
      apply = (wrap || !active) && (pend_q || div_load);
      if (apply) begin
         div_cur_d = div_load ? div_in : pend_val_q;
         pend_d    = 1'b0;
         div_ack_d = 1'b1;
      end else if (div_load) begin
         pend_val_d = div_in;
         pend_d     = 1'b1;
      end
      neff_nx = (div_cur_d == '0) ? CNT_W'(1) : div_cur_d;

      if (!active || wrap) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end

      clk_en_d = wrap;
      // The wrap edge looks at the newly applied divisor so the first high phase is already correct.
      clk_div_d = active && (cnt_d < (neff_nx >> 1));

      case (state_q)
         IDLE: begin
            if (run) begin
               state_d = RUN;
            end else if (step) begin
               state_d = STEP;
            end
         end
         RUN: begin
            if (wrap && !run) begin
               state_d = IDLE;
            end
         end
         STEP: begin
            if (wrap) begin
               state_d = run ? RUN : IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         div_cur_q  <= CNT_W'(DEFAULT_DIV);
         pend_val_q <= '0;
         pend_q     <= 1'b0;
         clk_en_q   <= 1'b0;
         clk_div_q  <= 1'b0;
         div_ack_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         div_cur_q  <= div_cur_d;
         pend_val_q <= pend_val_d;
         pend_q     <= pend_d;
         clk_en_q   <= clk_en_d;
         clk_div_q  <= clk_div_d;
         div_ack_q  <= div_ack_d;
      end
   end

   assign div_ack = div_ack_q;
   assign div_cur = div_cur_q;
   assign clk_en  = clk_en_q;
   assign clk_div = clk_div_q;
   assign busy    = (state_q != IDLE);

endmodule
